// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and width helpers
// for the FFT butterfly datapath.
package fft_pkg;

    localparam int WL      = 16;
    localparam int WL_TW   = 14;
    localparam int TW_FRAC = WL_TW - 2;
    localparam int BFLY_LAT = 4;

    typedef struct packed {
        logic signed [WL-1:0] re;
        logic signed [WL-1:0] im;
    } cplx_t;

    function automatic int prod_w(input int dw, input int tw);
        return dw + tw;
    endfunction

    function automatic int tw_frac(input int tw);
        return tw - 2;
    endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Two-register complex multiplier: full-precision products,
// then rescaled sum truncated to one bit above the data width.
module cmul_pipe
    import fft_pkg::*;
#(
    parameter int DW = WL,
    parameter int TW = WL_TW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW:0]   t_re,
    output logic signed [DW:0]   t_im
);

    localparam int PW   = prod_w(DW, TW);
    localparam int FRAC = tw_frac(TW);

    logic signed [PW-1:0] p_rc;
    logic signed [PW-1:0] p_is;
    logic signed [PW-1:0] p_rs;
    logic signed [PW-1:0] p_ic;
    logic signed [PW:0]   s_re;
    logic signed [PW:0]   s_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rc <= '0;
            p_is <= '0;
            p_rs <= '0;
            p_ic <= '0;
        end else begin
            p_rc <= PW'(b_re) * PW'(w_re);
            p_is <= PW'(b_im) * PW'(w_im);
            p_rs <= PW'(b_re) * PW'(w_im);
            p_ic <= PW'(b_im) * PW'(w_re);
        end
    end

    // one guard bit keeps the sum exact before rescaling
    always_comb begin
        s_re = (PW+1)'(p_rc) - (PW+1)'(p_is);
        s_im = (PW+1)'(p_rs) + (PW+1)'(p_ic);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_re <= '0;
            t_im <= '0;
        end else begin
            t_re <= (DW+1)'(s_re >>> FRAC);
            t_im <= (DW+1)'(s_im >>> FRAC);
        end
    end

endmodule

// File: rtl/fft_sec_butterfly.sv
// Second-stage radix-2 DIT butterfly: A' = (A + B*W)/2,
// B' = (A - B*W)/2, four-cycle pipeline, twiddle ROM read port.
module fft_sec_butterfly
    import fft_pkg::*;
#(
    parameter int stage_FFT      = 2,
    parameter int SIZE           = 10,
    parameter int word_length    = WL,
    parameter int word_length_tw = WL_TW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [word_length-1:0] in_a_re,
    input  logic signed [word_length-1:0] in_a_im,
    input  logic signed [word_length-1:0] in_b_re,
    input  logic signed [word_length-1:0] in_b_im,
    output logic                          en_rd,
    output logic [stage_FFT-2:0]          rd_ptr_angle,
    input  logic signed [word_length_tw-1:0] cos_data,
    input  logic signed [word_length_tw-1:0] sin_data,
    output logic                          out_valid,
    output logic signed [word_length-1:0] out_a_re,
    output logic signed [word_length-1:0] out_a_im,
    output logic signed [word_length-1:0] out_b_re,
    output logic signed [word_length-1:0] out_b_im,
    output logic                          frame_done
);

    localparam int DW = word_length;

    logic [SIZE-2:0] pair_cnt;
    logic            v1, v2, v3;
    logic            l1, l2, l3;

    logic signed [DW-1:0] a1_re, a1_im;
    logic signed [DW-1:0] a2_re, a2_im;
    logic signed [DW-1:0] a3_re, a3_im;
    logic signed [DW-1:0] b1_re, b1_im;
    logic signed [DW:0]   t_re, t_im;

    logic signed [DW+1:0] sa_re, sa_im;
    logic signed [DW+1:0] sb_re, sb_im;

    assign en_rd        = in_valid;
    assign rd_ptr_angle = pair_cnt[stage_FFT-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt <= '0;
        end else if (in_valid) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end

    // S1: capture the pair while the ROM answers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            l1    <= 1'b0;
            a1_re <= '0;
            a1_im <= '0;
            b1_re <= '0;
            b1_im <= '0;
        end else begin
            v1 <= in_valid;
            l1 <= in_valid & (&pair_cnt);
            if (in_valid) begin
                a1_re <= in_a_re;
                a1_im <= in_a_im;
                b1_re <= in_b_re;
                b1_im <= in_b_im;
            end
        end
    end

    cmul_pipe #(
        .DW(word_length),
        .TW(word_length_tw)
    ) u_cmul (
        .clk (clk),
        .rst (rst),
        .b_re(b1_re),
        .b_im(b1_im),
        .w_re(cos_data),
        .w_im(sin_data),
        .t_re(t_re),
        .t_im(t_im)
    );

    // A and the control bits ride alongside the multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            v3    <= 1'b0;
            l2    <= 1'b0;
            l3    <= 1'b0;
            a2_re <= '0;
            a2_im <= '0;
            a3_re <= '0;
            a3_im <= '0;
        end else begin
            v2    <= v1;
            v3    <= v2;
            l2    <= l1;
            l3    <= l2;
            a2_re <= a1_re;
            a2_im <= a1_im;
            a3_re <= a2_re;
            a3_im <= a2_im;
        end
    end

    always_comb begin
        sa_re = (DW+2)'(a3_re) + (DW+2)'(t_re);
        sa_im = (DW+2)'(a3_im) + (DW+2)'(t_im);
        sb_re = (DW+2)'(a3_re) - (DW+2)'(t_re);
        sb_im = (DW+2)'(a3_im) - (DW+2)'(t_im);
    end

    // S4: halve with floor rounding, wrap to data width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_a_re   <= '0;
            out_a_im   <= '0;
            out_b_re   <= '0;
            out_b_im   <= '0;
        end else begin
            out_valid  <= v3;
            frame_done <= v3 & l3;
            if (v3) begin
                out_a_re <= DW'(sa_re >>> 1);
                out_a_im <= DW'(sa_im >>> 1);
                out_b_re <= DW'(sb_re >>> 1);
                out_b_im <= DW'(sb_im >>> 1);
            end
        end
    end

endmodule

// File: tb/tb_fft_sec_butterfly.sv
// Scoreboard bench for fft_sec_butterfly with a one-cycle
// twiddle ROM model.
module tb_fft_sec_butterfly;
    import fft_pkg::*;

    localparam int NP = 512;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic signed [15:0] in_a_re, in_a_im, in_b_re, in_b_im;
    logic en_rd;
    logic [0:0] rd_ptr_angle;
    logic signed [13:0] cos_data, sin_data;
    logic out_valid;
    logic signed [15:0] out_a_re, out_a_im, out_b_re, out_b_im;
    logic frame_done;

    fft_sec_butterfly dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_a_re     (in_a_re),
        .in_a_im     (in_a_im),
        .in_b_re     (in_b_re),
        .in_b_im     (in_b_im),
        .en_rd       (en_rd),
        .rd_ptr_angle(rd_ptr_angle),
        .cos_data    (cos_data),
        .sin_data    (sin_data),
        .out_valid   (out_valid),
        .out_a_re    (out_a_re),
        .out_a_im    (out_a_im),
        .out_b_re    (out_b_re),
        .out_b_im    (out_b_im),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    logic signed [13:0] tab_c [2];
    logic signed [13:0] tab_s [2];

    always @(posedge clk)
        if (en_rd) begin
            cos_data <= tab_c[rd_ptr_angle];
            sin_data <= tab_s[rd_ptr_angle];
        end

    typedef struct {
        cplx_t oa;
        cplx_t ob;
        logic  last;
        int    cyc;
    } exp_t;

    exp_t sbq[$];
    int cyc = 0;
    int idx = 0;
    int fd_cnt = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(
        input logic signed [15:0] ar, ai, br, bi,
        input logic signed [13:0] c, s
    );
        exp_t m;
        longint tr, ti, q;
        logic signed [16:0] t17r, t17i;
        tr = (longint'(br) * c - longint'(bi) * s) >>> TW_FRAC;
        ti = (longint'(br) * s + longint'(bi) * c) >>> TW_FRAC;
        t17r = tr[16:0];
        t17i = ti[16:0];
        q = (longint'(ar) + longint'(t17r)) >>> 1;
        m.oa.re = q[15:0];
        q = (longint'(ai) + longint'(t17i)) >>> 1;
        m.oa.im = q[15:0];
        q = (longint'(ar) - longint'(t17r)) >>> 1;
        m.ob.re = q[15:0];
        q = (longint'(ai) - longint'(t17i)) >>> 1;
        m.ob.im = q[15:0];
        m.last = 1'b0;
        m.cyc = 0;
        return m;
    endfunction

    task automatic issue(input int ar, input int ai, input int br, input int bi);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a_re = 16'(ar);
        in_a_im = 16'(ai);
        in_b_re = 16'(br);
        in_b_im = 16'(bi);
        #1;
        check("ptr", int'(rd_ptr_angle), idx % 2);
        check("en_rd", int'(en_rd), 1);
        e = model(in_a_re, in_a_im, in_b_re, in_b_im,
                  tab_c[idx % 2], tab_s[idx % 2]);
        e.last = (idx == NP - 1);
        e.cyc = cyc;
        sbq.push_back(e);
        idx = (idx + 1) % NP;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("en_rd_idle", int'(en_rd), 0);
    endtask

    task automatic rnd_pair();
        issue($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
              $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (sbq.size() > 0 && sbq[0].cyc + BFLY_LAT < cyc) begin
            check("lost_pair", 0, 1);
            void'(sbq.pop_front());
        end
        exp_v = (sbq.size() > 0) && (sbq[0].cyc + BFLY_LAT == cyc);
        check("out_valid", int'(out_valid), int'(exp_v));
        if (frame_done) fd_cnt++;
        if (exp_v) begin
            e = sbq.pop_front();
            check("frame_done", int'(frame_done), int'(e.last));
            if (out_valid) begin
                check("a_re", int'(out_a_re), int'(e.oa.re));
                check("a_im", int'(out_a_im), int'(e.oa.im));
                check("b_re", int'(out_b_re), int'(e.ob.re));
                check("b_im", int'(out_b_im), int'(e.ob.im));
            end
        end else begin
            check("frame_done_idle", int'(frame_done), 0);
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a_re = '0;
        in_a_im = '0;
        in_b_re = '0;
        in_b_im = '0;
        tab_c[0] = 14'sd4096;
        tab_s[0] = 14'sd0;
        tab_c[1] = 14'sd0;
        tab_s[1] = -14'sd4096;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_a_re", int'(out_a_re), 0);
        check("rst_b_im", int'(out_b_im), 0);
        check("rst_ptr", int'(rd_ptr_angle), 0);
        rst = 1'b0;

        issue(100, 0, 50, 0);
        issue(100, 0, 50, 0);
        issue(0, 0, -3, 0);
        issue(-32768, 32767, -32768, -32768);
        idle();
        issue(1234, -999, 32767, 500);
        idle();
        issue(-7, 7, 1, -1);
        idle();
        idle();
        for (int i = 0; i < 6; i++) rnd_pair();
        idle();
        repeat (6) idle();

        issue(1, 2, 3, 4);
        issue(5, 6, 7, 8);
        issue(9, 10, 11, 12);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        idx = 0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_a_re", int'(out_a_re), 0);
        check("mid_rst_a_im", int'(out_a_im), 0);
        check("mid_rst_b_re", int'(out_b_re), 0);
        check("mid_rst_b_im", int'(out_b_im), 0);
        check("mid_rst_fd", int'(frame_done), 0);
        check("mid_rst_ptr", int'(rd_ptr_angle), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) idle();

        tab_c[0] = 14'sd8191;
        tab_s[0] = -14'sd8192;
        tab_c[1] = 14'sd2896;
        tab_s[1] = -14'sd2896;
        fd_cnt = 0;
        for (int i = 0; i < NP + 2; i++) rnd_pair();
        idle();
        repeat (8) idle();
        check("frame_count", fd_cnt, 1);
        check("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_sec_butterfly.md
# fft_sec_butterfly

Radix-2 DIT butterfly for the second FFT stage. It accepts one complex sample pair per valid cycle and drives the read port of the second-stage twiddle ROM. It computes A' = (A + B·W)/2 and B' = (A − B·W)/2 through a 4-cycle pipeline and passes the results to the next stage's reorder buffer. Upstream is the first-stage output buffer; downstream the twiddle ROM answers one cycle after `en_rd`.

## Interface
- `stage_FFT`, 2: stage index; the twiddle set has 2^(stage_FFT−1) entries.
- `SIZE`, 10: log2 of FFT points; a frame is 2^(SIZE−1) pairs.
- `word_length`, 16: signed data width (re and im each).
- `word_length_tw`, 14: signed twiddle width, Q2.(word_length_tw−2); +1.0 = 4096.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the input pair is valid this cycle.
- `in_a_re`, `in_a_im`, `in_b_re`, `in_b_im`  in  word_length each  signed A and B samples.
- `en_rd`  out  1  twiddle read enable, equal to `in_valid` (combinational).
- `rd_ptr_angle`  out  stage_FFT−1  twiddle index, equal to `pair_cnt[stage_FFT−2:0]` (registered counter).
- `cos_data`, `sin_data`  in  word_length_tw each  W real and imaginary parts, valid the cycle after `en_rd`.
- `out_valid`  out  1  the output pair is valid.
- `out_a_re`, `out_a_im`, `out_b_re`, `out_b_im`  out  word_length each  signed results.
- `frame_done`  out  1  one-cycle pulse together with the `out_valid` of the last pair of a frame.

## Operation
- `pair_cnt` is SIZE−1 bits, increments on each `in_valid`, and wraps from 2^(SIZE−1)−1 to 0. A `last` flag is set when `pair_cnt` is at its maximum and travels with the pair.
- W = cos_data + j·sin_data. The ROM already stores the signed imaginary part, so no negation is done here.
- S1 (T+1): register A, B, valid and last. `cos_data` and `sin_data` are valid in this cycle.
- S2 (T+2): register four products: b_re·cos, b_im·sin, b_re·sin, b_im·cos. Each is word_length+word_length_tw bits, full precision.
- S3 (T+3): t_re = (b_re·cos − b_im·sin) >>> (word_length_tw−2) and t_im = (b_re·sin + b_im·cos) >>> (word_length_tw−2). The sum uses one guard bit. Truncate to word_length+1 bits.
- S4 (T+4): out_a = (A + t) >>> 1 and out_b = (A − t) >>> 1, computed per component in word_length+2 bits and then truncated to word_length. `>>>` is arithmetic shift, i.e. floor rounding, with no saturation.
- There is no backpressure. Gaps in `in_valid` become gaps in `out_valid`, and data in the pipeline keeps advancing regardless.

## Timing
- Latency from `in_valid` to `out_valid` is exactly 4 cycles. Throughput is one pair per cycle.
- `en_rd` goes high in the same cycle as `in_valid`. `rd_ptr_angle` is stable in that cycle because it comes from the registered counter.
- Reset values: `pair_cnt`=0, all pipeline valid and last bits = 0, `out_valid`=0, `frame_done`=0, all data outputs = 0.
- Data registers are cleared by `rst`, not just by their valid bits.
- Reset mid-frame: every in-flight pair is dropped and no `out_valid` appears for 4 cycles after release. The next accepted pair uses index 0.
- Counter wrap and a new frame on back-to-back cycles is legal. `frame_done` for frame n and the first output of frame n+1 then appear on consecutive cycles.
- `out_*` values are don't-care while `out_valid`=0. They are held from the last update.

## Structure
- Shared package `fft_pkg`: constants `TW_FRAC = word_length_tw−2` and `BFLY_LAT = 4`, plus the signed complex type and its width helpers.
- Sub-module `cmul_pipe`: a 2-register complex multiplier covering S2–S3. Its inputs are B and W; its outputs are t_re and t_im. It is also planned for reuse in later stages.
- The top level holds the counter, S1, S4, and the valid/last shift chain.

## Test plan
- W0: `in_valid` with A=(100,0), B=(50,0), ptr 0, ROM returning (4096,0). Expect `out_valid` at T+4 with out_a=(75,0) and out_b=(25,0).
- W1: the next pair A=(100,0), B=(50,0), ptr 1, ROM returning (0,−4096). Expect out_a=(50,−25) and out_b=(50,25).
- Rounding: A=(0,0), B=(−3,0), W0. Expect out_a=(−2,0) and out_b=(1,0), showing floor rounding.
- Frame: 512 back-to-back pairs with SIZE=10. Expect `rd_ptr_angle` to alternate 0,1,…, and exactly one `frame_done` together with the 512th `out_valid`. The next pair uses ptr 0.
- Gaps: a valid/idle/valid pattern produces the same pattern on `out_valid` with latency 4. The pointer advances only on valid cycles.
- Reset: assert `rst` while 3 pairs are in flight. Expect all outputs to go to 0 immediately, no spurious `out_valid`, and the next pair to use ptr 0.
